// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// saturating to all nines when the input does not fit in DIGITS digits.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned WORK_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned CMP_W   = (BIN_W > 32) ? BIN_W : 32;
  localparam int unsigned BCD_MAX = (10 ** DIGITS) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [WORK_W-1:0]   work, work_next;
  logic [WORK_W-1:0]   work_adj;
  logic [WORK_W-1:0]   work_sh;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [BCD_W-1:0]    bcd_next;
  logic                ovf_next;
  logic                busy_next;
  logic                done_next;
  logic                ovf_pend, ovf_pend_next;
  logic                is_over;

  // Input out of range for DIGITS decimal digits; latched at the accepting edge.
  assign is_over = CMP_W'(bin) > CMP_W'(BCD_MAX);

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    work_adj = work;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (work[BIN_W + 4*d +: 4] >= 4'd5) begin
        work_adj[BIN_W + 4*d +: 4] = work[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    work_sh = {work_adj[WORK_W-2:0], 1'b0};
  end

  // Next-state, datapath and output-register next values.
  always_comb begin
    state_next    = state;
    work_next     = work;
    cnt_next      = cnt;
    bcd_next      = bcd;
    ovf_next      = ovf;
    ovf_pend_next = ovf_pend;
    busy_next     = busy;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          state_next    = CONV;
          work_next     = {BCD_W'(0), bin};
          cnt_next      = '0;
          ovf_pend_next = is_over;
          busy_next     = 1'b1;
        end
      end
      CONV: begin
        work_next = work_sh;
        cnt_next  = cnt + CNT_W'(1);
        busy_next = 1'b1;
        // This edge performs the final shift, so publish the shifted value.
        if (cnt == CNT_W'(BIN_W - 1)) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          if (ovf_pend) begin
            bcd_next = {DIGITS{4'h9}};
            ovf_next = 1'b1;
          end else begin
            bcd_next = work_sh[WORK_W-1 -: BCD_W];
            ovf_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      work     <= work_next;
      cnt      <= cnt_next;
      bcd      <= bcd_next;
      ovf      <= ovf_next;
      ovf_pend <= ovf_pend_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random regression
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] bin;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bin   (bin),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of min(v, 9999), built with division
  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((s / (10 ** i)) % 10);
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v);
    return (v > 9999) ? 1'b1 : 1'b0;
  endfunction

  // One conversion with a single-cycle start, checking latency and results
  task automatic conv(input int v, input string tag);
    int n;
    int busy_cnt;
    @(negedge clk);
    bin   = 14'(v);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    while (n < 40 && done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"},  32'(n), 32'(BIN_W));
    check({tag, "_busyn"}, 32'(busy_cnt), 32'(BIN_W));
    check({tag, "_busy0"}, 32'(busy), 32'(0));
    check({tag, "_bcd"},  32'(bcd), 32'(ref_bcd(v)));
    check({tag, "_ovf"},  32'(ovf), 32'(ref_ovf(v)));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'(0));
    check({tag, "_hold"},  32'(bcd), 32'(ref_bcd(v)));
  endtask

  initial begin
    int ndone;
    int t;
    int times[2];
    logic [15:0] vals[2];
    logic [15:0] val;

    reset = 1'b1;
    bin   = '0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bcd",  32'(bcd),  32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ovf",  32'(ovf),  32'(0));
    reset = 1'b0;

    // Basic and boundary conversions
    conv(1234,  "basic");
    conv(0,     "zero");
    conv(9999,  "max");
    conv(10000, "ovf10k");
    conv(16383, "ovffull");
    conv(1,     "one");

    // Start while busy is ignored
    @(negedge clk);
    bin   = 14'd42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin   = 14'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    val   = '0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        val = bcd;
      end
    end
    check("busy_ndone", 32'(ndone), 32'(1));
    check("busy_bcd",   32'(val),   32'h0042);
    check("busy_ovf",   32'(ovf),   32'(0));

    // Back-to-back with start held high
    @(negedge clk);
    bin   = 14'd58;
    start = 1'b1;
    t     = 0;
    ndone = 0;
    while (t < 60 && ndone < 2) begin
      @(negedge clk);
      t++;
      if (t == 5) bin = 14'd305;
      if (done === 1'b1) begin
        times[ndone] = t;
        vals[ndone]  = bcd;
        ndone++;
        if (ndone == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_ndone", 32'(ndone), 32'(2));
    if (ndone == 2) begin
      check("b2b_gap",  32'(times[1] - times[0]), 32'(15));
      check("b2b_bcd0", 32'(vals[0]), 32'h0058);
      check("b2b_bcd1", 32'(vals[1]), 32'h0305);
    end
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'(0));

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    bin   = 14'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_bcd",  32'(bcd),  32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_ovf",  32'(ovf),  32'(0));
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("arst_nodone", 32'(ndone), 32'(0));
    check("arst_bcdkeep", 32'(bcd), 32'(0));
    check("arst_idle", 32'(busy), 32'(0));

    // Random regression
    for (int k = 0; k < 500; k++) begin
      conv(int'($urandom_range(0, 16383)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
